// File: rtl/one_hot_decoder.sv
// one_hot_decoder: binary lane index in, registered one-hot strobe out.
// A strobe is held until the selected lane acks or TIMEOUT cycles pass.
// Indices >= OH_W are consumed and flagged with err_invalid.
// Optional macro ONEHOT_DEC_SKID_EN adds a one-entry skid buffer so a
// queued request launches with no idle cycle between strobes.
module one_hot_decoder #(
  parameter int OH_W    = 16,
  parameter int IDX_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  output logic [OH_W-1:0]  out_onehot,
  output logic             out_valid,
  input  logic [OH_W-1:0]  out_ack,
  output logic [IDX_W-1:0] cur_idx,
  output logic             done,
  output logic             timeout,
  output logic             err_invalid
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int SEL_W = $clog2(OH_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LIM = IDX_W'(OH_W);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [OH_W-1:0]  onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             err_q, err_d;

  logic             accept;
  logic             ack_sel;
  logic             clear;
  logic             launch;
  logic [IDX_W-1:0] launch_idx;

`ifdef ONEHOT_DEC_SKID_EN
  logic             skid_vld_q, skid_vld_d;
  logic [IDX_W-1:0] skid_idx_q, skid_idx_d;
  logic             err_pend_q, err_pend_d;

  assign in_ready = !skid_vld_q;
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept  = in_valid & in_ready;
  assign ack_sel = out_ack[idx_q[SEL_W-1:0]];

  // Next-state and registered-output decode; clear and launch are applied
  // last so a completion can hand straight over to the next strobe.
  always_comb begin
    state_d    = state_q;
    onehot_d   = onehot_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    err_d      = 1'b0;
    clear      = 1'b0;
    launch     = 1'b0;
    launch_idx = in_idx;
`ifdef ONEHOT_DEC_SKID_EN
    skid_vld_d = skid_vld_q;
    skid_idx_d = skid_idx_q;
    err_pend_d = 1'b0;
    // A deferred error pulse lands one cycle after done/timeout.
    err_d      = err_pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_idx < IDX_LIM) begin
            launch = 1'b1;
          end else begin
`ifdef ONEHOT_DEC_SKID_EN
            // Keep one pulse per bad request if a deferred one is in flight.
            if (err_pend_q) err_pend_d = 1'b1;
            else            err_d      = 1'b1;
`else
            err_d = 1'b1;
`endif
          end
        end
      end
      BUSY: begin
        if (ack_sel) begin
          done_d = 1'b1;
          clear  = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          tmo_d = 1'b1;
          clear = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef ONEHOT_DEC_SKID_EN
        if (clear) begin
          if (skid_vld_q) begin
            skid_vld_d = 1'b0;
            skid_idx_d = '0;
            if (skid_idx_q < IDX_LIM) begin
              launch     = 1'b1;
              launch_idx = skid_idx_q;
            end else begin
              err_pend_d = 1'b1;
            end
          end else if (accept) begin
            if (in_idx < IDX_LIM) launch     = 1'b1;
            else                  err_pend_d = 1'b1;
          end
        end else if (accept) begin
          skid_vld_d = 1'b1;
          skid_idx_d = in_idx;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d  = IDLE;
      onehot_d = '0;
      valid_d  = 1'b0;
      idx_d    = '0;
      cnt_d    = '0;
    end
    if (launch) begin
      state_d  = BUSY;
      onehot_d = '0;
      onehot_d[launch_idx[SEL_W-1:0]] = 1'b1;
      valid_d  = 1'b1;
      idx_d    = launch_idx;
      cnt_d    = '0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

`ifdef ONEHOT_DEC_SKID_EN
  // Skid buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_q <= 1'b0;
      skid_idx_q <= '0;
      err_pend_q <= 1'b0;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_idx_q <= skid_idx_d;
      err_pend_q <= err_pend_d;
    end
  end
`endif

  assign out_onehot  = onehot_q;
  assign out_valid   = valid_q;
  assign cur_idx     = idx_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign err_invalid = err_q;

endmodule

// File: tb/tb_one_hot_decoder.sv
// Testbench for one_hot_decoder: a cycle model pushes expected outputs into
// a scoreboard queue at each clock edge; they are popped and compared on the
// following falling edge. Directed sequences add explicit constant checks.
module tb_one_hot_decoder;
  localparam int OH_W    = 16;
  localparam int IDX_W   = 5;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [OH_W-1:0]  out_onehot;
  logic             out_valid;
  logic [OH_W-1:0]  out_ack;
  logic [IDX_W-1:0] cur_idx;
  logic             done;
  logic             timeout;
  logic             err_invalid;

  always #5 clk = ~clk;

  one_hot_decoder #(.OH_W(OH_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .out_onehot(out_onehot), .out_valid(out_valid),
    .out_ack(out_ack), .cur_idx(cur_idx), .done(done), .timeout(timeout),
    .err_invalid(err_invalid)
  );

  typedef struct packed {
    logic [OH_W-1:0]  oh;
    logic             v;
    logic [IDX_W-1:0] idx;
    logic             d;
    logic             t;
    logic             e;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state.
  bit m_busy;
  int m_lane;
  int m_cnt;
  bit m_skv;
  int m_ski;
  bit m_errp;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_lane = 0; m_cnt = 0;
    m_skv = 0; m_ski = 0; m_errp = 0;
    sb.delete();
  endtask

  function automatic bit model_ready();
`ifdef ONEHOT_DEC_SKID_EN
    return !m_skv;
`else
    return !m_busy;
`endif
  endfunction

  // One clock of stimulus: drive, check ready, advance model, compare outputs.
  task automatic step(input bit v, input int idx, input logic [OH_W-1:0] ack);
    exp_t e;
    bit acc, nd, nt, ne, np, clr;
    in_valid = v;
    in_idx   = idx[IDX_W-1:0];
    out_ack  = ack;
    #1;
    check_eq("in_ready", in_ready, model_ready());
    acc = v && model_ready();
    nd = 0; nt = 0; ne = 0; np = 0; clr = 0;
`ifdef ONEHOT_DEC_SKID_EN
    ne = m_errp;
`endif
    if (!m_busy) begin
      if (acc) begin
        if (idx < OH_W) begin
          m_busy = 1; m_lane = idx; m_cnt = 0;
        end else begin
`ifdef ONEHOT_DEC_SKID_EN
          if (m_errp) np = 1; else ne = 1;
`else
          ne = 1;
`endif
        end
      end
    end else begin
      if (ack[m_lane]) begin nd = 1; clr = 1; end
      else if (m_cnt == TIMEOUT - 1) begin nt = 1; clr = 1; end
      else m_cnt++;
      if (clr) m_busy = 0;
`ifdef ONEHOT_DEC_SKID_EN
      if (clr) begin
        if (m_skv) begin
          m_skv = 0;
          if (m_ski < OH_W) begin m_busy = 1; m_lane = m_ski; m_cnt = 0; end
          else np = 1;
        end else if (acc) begin
          if (idx < OH_W) begin m_busy = 1; m_lane = idx; m_cnt = 0; end
          else np = 1;
        end
      end else if (acc) begin
        m_skv = 1; m_ski = idx;
      end
`endif
    end
    m_errp = np;
    e = '0;
    if (m_busy) begin
      e.oh[m_lane] = 1'b1;
      e.v   = 1'b1;
      e.idx = m_lane[IDX_W-1:0];
    end
    e.d = nd; e.t = nt; e.e = ne;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq("onehot", out_onehot, e.oh);
      check_eq("valid", out_valid, e.v);
      check_eq("cur_idx", cur_idx, e.idx);
      check_eq("done", done, e.d);
      check_eq("timeout", timeout, e.t);
      check_eq("err_invalid", err_invalid, e.e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_oh"}, out_onehot, '0);
    check_eq({tag, "_v"}, out_valid, 0);
    check_eq({tag, "_idx"}, cur_idx, '0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_tmo"}, timeout, 0);
    check_eq({tag, "_err"}, err_invalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [OH_W-1:0] rack;
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; out_ack = '0;
    model_reset();
    #1;
    check_all_zero("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", in_ready, 1);
    @(negedge clk);

    // Lane 5, acked two cycles after accept.
    step(1, 5, '0);
    check_eq("t5_oh", out_onehot, 16'h0020);
    step(0, 0, '0);
    step(0, 0, 16'h0020);
    check_eq("t5_done", done, 1);
    check_eq("t5_clear", out_onehot, 16'h0000);
    step(0, 0, '0);

    // Invalid codes.
    step(1, 16, '0);
    check_eq("inv16_err", err_invalid, 1);
    step(1, 31, '0);
    check_eq("inv31_err", err_invalid, 1);
    check_eq("inv31_v", out_valid, 0);
    step(0, 0, '0);

    // Lane 15 left to time out.
    step(1, 15, '0);
    cnt = 0;
    while (out_onehot == 16'h8000 && cnt < 200) begin
      cnt++;
      step(0, 0, '0);
    end
    check_eq("tmo_len", cnt, TIMEOUT);
    check_eq("tmo_pulse", timeout, 1);
    step(0, 0, '0);

    // Lane 3: wrong-lane acks ignored, real ack on the timeout boundary.
    step(1, 3, '0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 16'hFFF7);
    check_eq("b_hold", out_onehot, 16'h0008);
    step(0, 0, 16'hFFFF);
    check_eq("b_done", done, 1);
    check_eq("b_tmo", timeout, 0);
    step(0, 0, '0);

    // Asynchronous reset mid-BUSY.
    step(1, 8, '0);
    step(0, 0, '0);
    check_eq("r_oh", out_onehot, 16'h0100);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    model_reset();
    rst = 1'b0;
    step(0, 0, '0);

`ifdef ONEHOT_DEC_SKID_EN
    // Back-to-back requests through the skid.
    step(1, 2, '0);
    check_eq("sk_oh2", out_onehot, 16'h0004);
    step(1, 9, '0);
    #1;
    check_eq("sk_full", in_ready, 0);
    @(negedge clk);
    step(0, 0, 16'h0004);
    check_eq("sk_oh9", out_onehot, 16'h0200);
    check_eq("sk_done", done, 1);
    step(0, 0, 16'h0200);
    step(0, 0, '0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rack = ($urandom_range(0, 3) == 0) ? OH_W'($urandom) : '0;
      step($urandom_range(0, 1) == 1,
           ($urandom_range(0, 4) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15),
           rack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
